// File: rtl/clkdiv_pkg.sv
// Shared types for the phased clock divider.
package clkdiv_pkg;

    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned Q_W     = 2;

    typedef logic [Q_W-1:0] quarter_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/clkdiv_phase_gen.sv
// One phase output: holds its arm flag and decodes its rising/falling events
// from the next-edge counter position so out_o changes on exactly that edge.
module clkdiv_phase_gen
    import clkdiv_pkg::*;
#(
    parameter int unsigned K = 0
) (
    input  logic     CLK,
    input  logic     RST_N,
    input  quarter_t q_i,          // quarter index being entered on this edge
    input  logic     sub_zero_i,   // sub counter being entered is 0
    input  logic     arm_ok_i,     // run request sampled on this edge
    input  logic     drain_i,      // draining: falling events disarm
    input  logic     clear_i,      // entering IDLE: counter frozen, force low
    output logic     out_o,
    output logic     arm_o
);

    localparam quarter_t RISE_Q = quarter_t'(K);
    localparam quarter_t FALL_Q = quarter_t'(K + 2);

    logic     arm_q, arm_d;
    logic     out_q, out_d;
    logic     rise_c, fall_c;
    quarter_t qdiff_c;

    // Event decode, arm update and gated phase level for the coming edge
    always_comb begin
        rise_c  = !clear_i && sub_zero_i && (q_i == RISE_Q);
        fall_c  = !clear_i && sub_zero_i && (q_i == FALL_Q);
        arm_d   = arm_q;
        if (clear_i) begin
            arm_d = 1'b0;
        end else if (rise_c && arm_ok_i) begin
            arm_d = 1'b1;
        end else if (fall_c && drain_i) begin
            arm_d = 1'b0;
        end
        qdiff_c = q_i - RISE_Q;
        out_d   = arm_d && !qdiff_c[1];
    end

    // Arm flag and output register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            arm_q <= 1'b0;
            out_q <= 1'b0;
        end else begin
            arm_q <= arm_d;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;
    assign arm_o = arm_q;

endmodule

// File: rtl/clock_divider_phased.sv
// Runtime-programmable divider with up to four 90-degree-spaced outputs,
// period 4*S input clocks, glitch-free start and drain.
// Optional tick output is built only when CLKDIV_TICK_EN is defined.
module clock_divider_phased
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned NUM_OUT     = 2,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               en,
    input  logic [CNT_W-1:0]   div_ratio,
    output logic [NUM_OUT-1:0] clk_out,
`ifdef CLKDIV_TICK_EN
    output logic               tick,
`endif
    output logic               running
);

    localparam logic [CNT_W-1:0] DEF_S = (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);

    state_t             state_q, state_d;
    quarter_t           q_q, q_d;
    logic [CNT_W-1:0]   sub_q, sub_d;
    logic [CNT_W-1:0]   s_q, s_d;
    logic               running_q;
    logic [CNT_W-1:0]   ratio_eff_c;
    logic               start_c, sub_wrap_c, clear_c, drain_c, sub_zero_c;
    logic [NUM_OUT-1:0] arm_vec;

    // Next state, counter advance and ratio reload (only at start or period wrap)
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        sub_d       = sub_q;
        s_d         = s_q;
        ratio_eff_c = (div_ratio == '0) ? CNT_W'(1) : div_ratio;
        start_c     = (state_q == IDLE) && en;
        sub_wrap_c  = (sub_q == s_q - CNT_W'(1));

        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (arm_vec == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            q_d   = '0;
            sub_d = '0;
        end else if (start_c) begin
            q_d   = '0;
            sub_d = '0;
            s_d   = ratio_eff_c;
        end else if (sub_wrap_c) begin
            sub_d = '0;
            q_d   = q_q + quarter_t'(1);
            if (q_q == quarter_t'(3)) begin
                s_d = ratio_eff_c;
            end
        end else begin
            sub_d = sub_q + CNT_W'(1);
        end

        clear_c    = (state_d == IDLE);
        drain_c    = (state_q != IDLE) && !en;
        sub_zero_c = (sub_d == '0);
    end

    // FSM, counters, step register and running flag
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            q_q       <= '0;
            sub_q     <= '0;
            s_q       <= DEF_S;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            sub_q     <= sub_d;
            s_q       <= s_d;
            running_q <= (state_d != IDLE);
        end
    end

    assign running = running_q;

    // One phase generator per output, fed with the position entered on each edge
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_phase
        clkdiv_phase_gen #(
            .K(k)
        ) u_phase (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .q_i        (q_d),
            .sub_zero_i (sub_zero_c),
            .arm_ok_i   (en),
            .drain_i    (drain_c),
            .clear_i    (clear_c),
            .out_o      (clk_out[k]),
            .arm_o      (arm_vec[k])
        );
    end

`ifdef CLKDIV_TICK_EN
    // Period-start strobe while running, including the start edge
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tick <= 1'b0;
        end else begin
            tick <= (state_d == RUN) && (q_d == '0) && sub_zero_c;
        end
    end
`endif

endmodule

// File: tb/tb_clock_divider_phased.sv
// Self-checking bench for clock_divider_phased (NUM_OUT=4, CNT_W=16).
// Checks tick as well when CLKDIV_TICK_EN is defined.
module tb_clock_divider_phased;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned NUM_OUT = 4;

    logic               CLK;
    logic               RST_N;
    logic               en;
    logic [CNT_W-1:0]   div_ratio;
    logic [NUM_OUT-1:0] clk_out;
    logic               running;
`ifdef CLKDIV_TICK_EN
    logic               tick;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] exp_q[$];

    // reference model state: position within the period instead of q/sub
    int         m_state;
    int         m_pos;
    int         m_s;
    logic [3:0] m_arm;
    logic [3:0] m_out;
    logic       m_run;
    logic       m_tick;

    clock_divider_phased #(
        .CNT_W       (CNT_W),
        .NUM_OUT     (NUM_OUT),
        .DEFAULT_DIV (1)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .en        (en),
        .div_ratio (div_ratio),
        .clk_out   (clk_out),
`ifdef CLKDIV_TICK_EN
        .tick      (tick),
`endif
        .running   (running)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge
    task automatic model_step(input logic rst_v, input logic en_v, input int ratio_v);
        int eff;
        int nstate;
        eff = (ratio_v == 0) ? 1 : ratio_v;
        if (!rst_v) begin
            m_state = 0; m_pos = 0; m_s = 1; m_arm = '0; m_out = '0; m_run = 1'b0; m_tick = 1'b0;
            return;
        end
        nstate = m_state;
        case (m_state)
            0:       if (en_v) nstate = 1;
            1:       if (!en_v) nstate = 2;
            default: begin
                if (en_v) nstate = 1;
                else if (m_arm == 4'b0000) nstate = 0;
            end
        endcase
        if (nstate == 0) begin
            m_state = 0; m_pos = 0; m_arm = '0; m_out = '0; m_run = 1'b0; m_tick = 1'b0;
            return;
        end
        if (m_state == 0) begin
            m_pos = 0;
            m_s   = eff;
        end else begin
            m_pos++;
            if (m_pos == 4 * m_s) begin
                m_pos = 0;
                m_s   = eff;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (m_pos == k * m_s && en_v) m_arm[k] = 1'b1;
            if (m_pos == ((k + 2) % 4) * m_s && !en_v) m_arm[k] = 1'b0;
            m_out[k] = m_arm[k] && ((((m_pos / m_s) + 4 - k) % 4) < 2);
        end
        m_tick  = (nstate == 1) && (m_pos == 0);
        m_run   = 1'b1;
        m_state = nstate;
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic cycle(input logic rst_v, input logic en_v, input logic [CNT_W-1:0] ratio_v);
        logic [5:0] e;
        RST_N     = rst_v;
        en        = en_v;
        div_ratio = ratio_v;
        model_step(rst_v, en_v, int'(ratio_v));
        exp_q.push_back({m_out, m_run, m_tick});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check("clk_out", 32'(clk_out), 32'(e[5:2]));
        check("running", 32'(running), 32'(e[1]));
`ifdef CLKDIV_TICK_EN
        check("tick", 32'(tick), 32'(e[0]));
`endif
    endtask

    logic [3:0] pat0, pat1;
    int         last_nz, first_idle;
    logic       en_r;
    logic [CNT_W-1:0] ratio_r;

    initial begin
        RST_N = 1'b0; en = 1'b0; div_ratio = '0;

        // reset state
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'd1);
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        cycle(1'b1, 1'b0, 16'd1);

        // S=1 start: out0 = 1100, out1 = 0110, out0 high one cycle after en
        pat0 = '0; pat1 = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 16'd1);
            pat0 = {pat0[2:0], clk_out[0]};
            pat1 = {pat1[2:0], clk_out[1]};
        end
        check("t1_out0_pattern", 32'(pat0), 32'b1100);
        check("t1_out1_pattern", 32'(pat1), 32'b0110);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 16'd1);

        // S=3 for several periods
        for (int i = 0; i < 44; i++) cycle(1'b1, 1'b1, 16'd3);

        // ratio 3 -> 5 mid-period
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 16'd3);
        for (int i = 0; i < 50; i++) cycle(1'b1, 1'b1, 16'd5);

        // S=2 then drain
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 16'd2);
        check("t4_running_before", 32'(running), 32'd1);
        last_nz = -1; first_idle = -1;
        for (int i = 0; i < 40 && first_idle < 0; i++) begin
            cycle(1'b1, 1'b0, 16'd2);
            if (clk_out != '0) last_nz = i;
            if (!running) first_idle = i;
        end
        if (first_idle < 0) check("t4_drain_timeout", 32'd0, 32'd1);
        else check("t4_running_fall_delay", 32'(first_idle - last_nz), 32'd2);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'd2);
        check("t4_outputs_idle", 32'(clk_out), 32'd0);

        // en low for one cycle, back to RUN without restart
        for (int i = 0; i < 13; i++) cycle(1'b1, 1'b1, 16'd2);
        cycle(1'b1, 1'b0, 16'd2);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 16'd2);

        // div_ratio=0 behaves as S=1, reset mid-high
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1, 16'd0);
        cycle(1'b0, 1'b1, 16'd0);
        check("t6_reset_outputs", 32'(clk_out), 32'd0);
        check("t6_reset_running", 32'(running), 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 16'd0);

        // random run/stop/ratio/reset mix
        en_r = 1'b1; ratio_r = 16'd1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) en_r = ~en_r;
            if ($urandom_range(0, 9) == 0) ratio_r = CNT_W'($urandom_range(0, 3));
            cycle(($urandom_range(0, 99) != 0), en_r, ratio_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
